// File: rtl/id_ex_stage_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: RegDst encodings,
// the return-address register index, control bundle and helpers.
package id_ex_stage_reg_pkg;

    // Default ALUOp field width; the top module exposes it as a parameter.
    localparam int ALUOP_W = 4;

    // Link register written by jal-style instructions.
    localparam logic [4:0] REG_RA = 5'd31;

    // Destination register select coming from the decoder.
    typedef enum logic [1:0] {
        REGDST_RT  = 2'b00,
        REGDST_RD  = 2'b01,
        REGDST_RA  = 2'b10,
        REGDST_RSV = 2'b11   // reserved, behaves like REGDST_RT
    } regdst_e;

    // Single-bit control signals carried from ID into EX.
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
    } ctrl_t;

    // A bubble has every side-effecting control deasserted.
    localparam ctrl_t CTRL_BUBBLE = '0;

    // 32-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register
// a load currently in EX is about to write. Register 0 never matches.
module load_use_detect #(
    parameter int REG_AW = 5
) (
    input  logic              id_ex_valid,
    input  logic              id_ex_mem_read,
    input  logic [REG_AW-1:0] id_ex_write_register,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    output logic              load_use
);

    // Compare each source the ID instruction actually reads against the load's destination.
    always_comb begin
        load_use = id_ex_valid && id_ex_mem_read && (id_ex_write_register != '0) &&
                   ((id_uses_rs && (id_rs == id_ex_write_register)) ||
                    (id_uses_rt && (id_rt == id_ex_write_register)));
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble injection,
// branch flush and downstream memory hold.
// Optional hazard statistics counters are built when HAZARD_STATS_EN is defined.
module id_ex_stage_reg #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = id_ex_stage_reg_pkg::ALUOP_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [REG_AW-1:0]  ID_rs,
    input  logic [REG_AW-1:0]  ID_rt,
    input  logic [REG_AW-1:0]  ID_rd,
    input  logic               ID_uses_rs,
    input  logic               ID_uses_rt,
    input  logic               ID_RegWrite,
    input  logic               ID_MemRead,
    input  logic               ID_MemWrite,
    input  logic               ID_MemtoReg,
    input  logic [1:0]         ID_RegDst,
    input  logic               ID_ALUSrc,
    input  logic [ALUOP_W-1:0] ID_ALUOp,
    input  logic [DATA_W-1:0]  ID_read_data1,
    input  logic [DATA_W-1:0]  ID_read_data2,
    input  logic [DATA_W-1:0]  ID_imm_ext,
    input  logic [DATA_W-1:0]  ID_PC_plus4,
    input  logic               EX_flush,
    input  logic               MEM_hold,
    output logic [REG_AW-1:0]  ID_EX_rs,
    output logic [REG_AW-1:0]  ID_EX_rt,
    output logic               ID_EX_RegWrite,
    output logic               ID_EX_MemRead,
    output logic               ID_EX_MemWrite,
    output logic               ID_EX_MemtoReg,
    output logic               ID_EX_ALUSrc,
    output logic [ALUOP_W-1:0] ID_EX_ALUOp,
    output logic [DATA_W-1:0]  ID_EX_read_data1,
    output logic [DATA_W-1:0]  ID_EX_read_data2,
    output logic [DATA_W-1:0]  ID_EX_imm_ext,
    output logic [DATA_W-1:0]  ID_EX_PC_plus4,
    output logic [REG_AW-1:0]  ID_EX_Write_register,
    output logic               ID_EX_valid,
    output logic               stall_IF_ID,
    output logic [31:0]        load_use_count,
    output logic [31:0]        flush_count
);

    import id_ex_stage_reg_pkg::*;

    ctrl_t              ctrl_q,   ctrl_d;
    logic [ALUOP_W-1:0] alu_op_q, alu_op_d;
    logic [REG_AW-1:0]  rs_q,     rs_d;
    logic [REG_AW-1:0]  rt_q,     rt_d;
    logic [DATA_W-1:0]  rd1_q,    rd1_d;
    logic [DATA_W-1:0]  rd2_q,    rd2_d;
    logic [DATA_W-1:0]  imm_q,    imm_d;
    logic [DATA_W-1:0]  pc4_q,    pc4_d;
    logic [REG_AW-1:0]  wr_reg_q, wr_reg_d;
    logic               valid_q,  valid_d;

    logic               load_use;
    logic [REG_AW-1:0]  id_dest;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .id_ex_valid          (valid_q),
        .id_ex_mem_read       (ctrl_q.mem_read),
        .id_ex_write_register (wr_reg_q),
        .id_rs                (ID_rs),
        .id_rt                (ID_rt),
        .id_uses_rs           (ID_uses_rs),
        .id_uses_rt           (ID_uses_rt),
        .load_use             (load_use)
    );

    // Freeze PC and IF/ID on a memory hold or load-use hazard, unless a flush kills ID anyway.
    always_comb begin
        stall_IF_ID = !EX_flush && (MEM_hold || load_use);
    end

    // Resolve the architectural destination of the ID instruction; non-writers get register 0.
    always_comb begin
        // NOTE: every path assigns id_dest (default first), so no latch is inferred.
        id_dest = ID_rt;
        case (regdst_e'(ID_RegDst))
            REGDST_RD: id_dest = ID_rd;
            REGDST_RA: id_dest = REG_AW'(REG_RA);
            default:   id_dest = ID_rt;
        endcase
        if (!ID_RegWrite) begin
            id_dest = '0;
        end
    end

    // Next-state selection: flush beats hold, hold beats load-use bubble, else capture ID.
    always_comb begin
        ctrl_d   = ctrl_q;
        alu_op_d = alu_op_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd1_d    = rd1_q;
        rd2_d    = rd2_q;
        imm_d    = imm_q;
        pc4_d    = pc4_q;
        wr_reg_d = wr_reg_q;
        valid_d  = valid_q;

        if (EX_flush || (!MEM_hold && load_use)) begin
            ctrl_d   = CTRL_BUBBLE;
            alu_op_d = '0;
            rs_d     = '0;
            rt_d     = '0;
            rd1_d    = '0;
            rd2_d    = '0;
            imm_d    = '0;
            pc4_d    = '0;
            wr_reg_d = '0;
            valid_d  = 1'b0;
        end else if (!MEM_hold) begin
            ctrl_d.reg_write  = ID_RegWrite;
            ctrl_d.mem_read   = ID_MemRead;
            ctrl_d.mem_write  = ID_MemWrite;
            ctrl_d.mem_to_reg = ID_MemtoReg;
            ctrl_d.alu_src    = ID_ALUSrc;
            alu_op_d          = ID_ALUOp;
            rs_d              = ID_rs;
            rt_d              = ID_rt;
            rd1_d             = ID_read_data1;
            rd2_d             = ID_read_data2;
            imm_d             = ID_imm_ext;
            pc4_d             = ID_PC_plus4;
            wr_reg_d          = id_dest;
            valid_d           = 1'b1;
        end
    end

    // Pipeline register with synchronous reset to an empty (bubble) stage.
    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            ctrl_q   <= CTRL_BUBBLE;
            alu_op_q <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd1_q    <= '0;
            rd2_q    <= '0;
            imm_q    <= '0;
            pc4_q    <= '0;
            wr_reg_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            alu_op_q <= alu_op_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            imm_q    <= imm_d;
            pc4_q    <= pc4_d;
            wr_reg_q <= wr_reg_d;
            valid_q  <= valid_d;
        end
    end

    assign ID_EX_rs             = rs_q;
    assign ID_EX_rt             = rt_q;
    assign ID_EX_RegWrite       = ctrl_q.reg_write;
    assign ID_EX_MemRead        = ctrl_q.mem_read;
    assign ID_EX_MemWrite       = ctrl_q.mem_write;
    assign ID_EX_MemtoReg       = ctrl_q.mem_to_reg;
    assign ID_EX_ALUSrc         = ctrl_q.alu_src;
    assign ID_EX_ALUOp          = alu_op_q;
    assign ID_EX_read_data1     = rd1_q;
    assign ID_EX_read_data2     = rd2_q;
    assign ID_EX_imm_ext        = imm_q;
    assign ID_EX_PC_plus4       = pc4_q;
    assign ID_EX_Write_register = wr_reg_q;
    assign ID_EX_valid          = valid_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] lu_cnt_q, lu_cnt_d;
    logic [31:0] fl_cnt_q, fl_cnt_d;

    // Count real load-use stalls and flushes, saturating at all-ones.
    always_comb begin
        lu_cnt_d = lu_cnt_q;
        fl_cnt_d = fl_cnt_q;
        if (load_use && !EX_flush && !MEM_hold) begin
            lu_cnt_d = sat_inc(lu_cnt_q);
        end
        if (EX_flush) begin
            fl_cnt_d = sat_inc(fl_cnt_q);
        end
    end

    // Statistics registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            lu_cnt_q <= '0;
            fl_cnt_q <= '0;
        end else begin
            lu_cnt_q <= lu_cnt_d;
            fl_cnt_q <= fl_cnt_d;
        end
    end

    assign load_use_count = lu_cnt_q;
    assign flush_count    = fl_cnt_q;
`else
    assign load_use_count = 32'd0;
    assign flush_count    = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed hazard scenarios plus
// randomized traffic checked against a transaction-level reference model.
module tb_id_ex_stage_reg;

    // Expected contents of the ID/EX stage, laid out in output order.
    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        as;
        logic [3:0]  op;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  wr;
        logic        valid;
    } ex_t;

`ifdef HAZARD_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ID_rs, ID_rt, ID_rd;
    logic        ID_uses_rs, ID_uses_rt;
    logic        ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc;
    logic [1:0]  ID_RegDst;
    logic [3:0]  ID_ALUOp;
    logic [31:0] ID_read_data1, ID_read_data2, ID_imm_ext, ID_PC_plus4;
    logic        EX_flush, MEM_hold;

    logic [4:0]  ID_EX_rs, ID_EX_rt, ID_EX_Write_register;
    logic        ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUSrc;
    logic [3:0]  ID_EX_ALUOp;
    logic [31:0] ID_EX_read_data1, ID_EX_read_data2, ID_EX_imm_ext, ID_EX_PC_plus4;
    logic        ID_EX_valid, stall_IF_ID;
    logic [31:0] load_use_count, flush_count;

    int n_cmp  = 0;
    int n_fail = 0;

    ex_t         m;          // model of the stage contents
    logic [31:0] m_lu_cnt;
    logic [31:0] m_fl_cnt;

    id_ex_stage_reg dut (
        .clk                  (clk),
        .reset                (reset),
        .ID_rs                (ID_rs),
        .ID_rt                (ID_rt),
        .ID_rd                (ID_rd),
        .ID_uses_rs           (ID_uses_rs),
        .ID_uses_rt           (ID_uses_rt),
        .ID_RegWrite          (ID_RegWrite),
        .ID_MemRead           (ID_MemRead),
        .ID_MemWrite          (ID_MemWrite),
        .ID_MemtoReg          (ID_MemtoReg),
        .ID_RegDst            (ID_RegDst),
        .ID_ALUSrc            (ID_ALUSrc),
        .ID_ALUOp             (ID_ALUOp),
        .ID_read_data1        (ID_read_data1),
        .ID_read_data2        (ID_read_data2),
        .ID_imm_ext           (ID_imm_ext),
        .ID_PC_plus4          (ID_PC_plus4),
        .EX_flush             (EX_flush),
        .MEM_hold             (MEM_hold),
        .ID_EX_rs             (ID_EX_rs),
        .ID_EX_rt             (ID_EX_rt),
        .ID_EX_RegWrite       (ID_EX_RegWrite),
        .ID_EX_MemRead        (ID_EX_MemRead),
        .ID_EX_MemWrite       (ID_EX_MemWrite),
        .ID_EX_MemtoReg       (ID_EX_MemtoReg),
        .ID_EX_ALUSrc         (ID_EX_ALUSrc),
        .ID_EX_ALUOp          (ID_EX_ALUOp),
        .ID_EX_read_data1     (ID_EX_read_data1),
        .ID_EX_read_data2     (ID_EX_read_data2),
        .ID_EX_imm_ext        (ID_EX_imm_ext),
        .ID_EX_PC_plus4       (ID_EX_PC_plus4),
        .ID_EX_Write_register (ID_EX_Write_register),
        .ID_EX_valid          (ID_EX_valid),
        .stall_IF_ID          (stall_IF_ID),
        .load_use_count       (load_use_count),
        .flush_count          (flush_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------

    function automatic ex_t actual();
        return {ID_EX_rs, ID_EX_rt, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite,
                ID_EX_MemtoReg, ID_EX_ALUSrc, ID_EX_ALUOp, ID_EX_read_data1,
                ID_EX_read_data2, ID_EX_imm_ext, ID_EX_PC_plus4,
                ID_EX_Write_register, ID_EX_valid};
    endfunction

    // Does the ID instruction read the register a valid load in EX will write?
    function automatic bit model_hazard();
        if (!(m.valid && m.mr) || m.wr == 5'd0) return 1'b0;
        return (ID_uses_rs && ID_rs == m.wr) || (ID_uses_rt && ID_rt == m.wr);
    endfunction

    function automatic bit model_stall();
        return !EX_flush && (MEM_hold || model_hazard());
    endfunction

    // What the ID instruction looks like once it sits in EX.
    function automatic ex_t decoded();
        ex_t c;
        c.rs = ID_rs;  c.rt = ID_rt;
        c.rw = ID_RegWrite; c.mr = ID_MemRead; c.mw = ID_MemWrite;
        c.m2r = ID_MemtoReg; c.as = ID_ALUSrc; c.op = ID_ALUOp;
        c.d1 = ID_read_data1; c.d2 = ID_read_data2;
        c.imm = ID_imm_ext; c.pc = ID_PC_plus4;
        if (!ID_RegWrite)         c.wr = 5'd0;
        else if (ID_RegDst == 1)  c.wr = ID_rd;
        else if (ID_RegDst == 2)  c.wr = 5'd31;
        else                      c.wr = ID_rt;
        c.valid = 1'b1;
        return c;
    endfunction

    function automatic logic [31:0] exp_lu_cnt();
        return STATS_EN ? m_lu_cnt : 32'd0;
    endfunction

    function automatic logic [31:0] exp_fl_cnt();
        return STATS_EN ? m_fl_cnt : 32'd0;
    endfunction

    // Advance one clock; the model consumes the same inputs the DUT samples.
    task automatic tick();
        bit hz;
        @(posedge clk);
        hz = model_hazard();
        if (reset) begin
            m = '0; m_lu_cnt = '0; m_fl_cnt = '0;
        end else begin
            if (EX_flush && m_fl_cnt != 32'hFFFF_FFFF) m_fl_cnt = m_fl_cnt + 1;
            if (hz && !EX_flush && !MEM_hold && m_lu_cnt != 32'hFFFF_FFFF) m_lu_cnt = m_lu_cnt + 1;
            if (EX_flush)      m = '0;
            else if (MEM_hold) m = m;
            else if (hz)       m = '0;
            else               m = decoded();
        end
        #1;
    endtask

    task automatic clear_id();
        reset = 1'b0; EX_flush = 1'b0; MEM_hold = 1'b0;
        ID_rs = '0; ID_rt = '0; ID_rd = '0; ID_uses_rs = 1'b0; ID_uses_rt = 1'b0;
        ID_RegWrite = 1'b0; ID_MemRead = 1'b0; ID_MemWrite = 1'b0; ID_MemtoReg = 1'b0;
        ID_RegDst = 2'b00; ID_ALUSrc = 1'b0; ID_ALUOp = '0;
        ID_read_data1 = $urandom(); ID_read_data2 = $urandom();
        ID_imm_ext = $urandom(); ID_PC_plus4 = $urandom();
    endtask

    task automatic rand_id(input int reg_max);
        ID_rs = 5'($urandom_range(0, reg_max));
        ID_rt = 5'($urandom_range(0, reg_max));
        ID_rd = 5'($urandom_range(0, reg_max));
        ID_uses_rs = 1'($urandom_range(0, 1));
        ID_uses_rt = 1'($urandom_range(0, 1));
        ID_RegWrite = 1'($urandom_range(0, 1));
        ID_MemRead = ($urandom_range(0, 4) < 2);
        ID_MemWrite = 1'($urandom_range(0, 1));
        ID_MemtoReg = 1'($urandom_range(0, 1));
        ID_RegDst = 2'($urandom_range(0, 3));
        ID_ALUSrc = 1'($urandom_range(0, 1));
        ID_ALUOp = 4'($urandom_range(0, 15));
        ID_read_data1 = $urandom(); ID_read_data2 = $urandom();
        ID_imm_ext = $urandom(); ID_PC_plus4 = $urandom();
    endtask

    // Put "lw $dst" into ID (writes rt).
    task automatic drive_load(input logic [4:0] dst);
        clear_id();
        ID_rs = 5'd29; ID_uses_rs = 1'b1; ID_rt = dst;
        ID_RegWrite = 1'b1; ID_MemRead = 1'b1; ID_MemtoReg = 1'b1; ID_ALUSrc = 1'b1;
        ID_RegDst = 2'b00; ID_ALUOp = 4'd2;
    endtask

    // ---------------- scenarios ----------------

    task automatic test_reset();
        clear_id();
        rand_id(31);
        reset = 1'b1;
        tick();
        rand_id(31);
        tick();
        n_cmp++;
        if (actual() !== ex_t'(0)) begin
            n_fail++; $display("FAIL reset_regs: got %h expected 0", actual());
        end
        n_cmp++;
        if (stall_IF_ID !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b expected 0", stall_IF_ID);
        end
        n_cmp++;
        if (load_use_count !== 32'd0 || flush_count !== 32'd0) begin
            n_fail++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", load_use_count, flush_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_load_use();
        drive_load(5'd8);
        tick();
        n_cmp++;
        if (actual() !== m || ID_EX_Write_register !== 5'd8) begin
            n_fail++; $display("FAIL lw_capture: got %h expected %h", actual(), m);
        end
        // add $10, $8, $9 in ID
        clear_id();
        ID_rs = 5'd8; ID_uses_rs = 1'b1; ID_rt = 5'd9; ID_uses_rt = 1'b1; ID_rd = 5'd10;
        ID_RegWrite = 1'b1; ID_RegDst = 2'b01; ID_ALUOp = 4'd1;
        #2;
        n_cmp++;
        if (stall_IF_ID !== 1'b1) begin
            n_fail++; $display("FAIL lu_stall: got %b expected 1", stall_IF_ID);
        end
        tick();
        n_cmp++;
        if (ID_EX_valid !== 1'b0 || actual() !== ex_t'(0)) begin
            n_fail++; $display("FAIL lu_bubble: got %h expected 0", actual());
        end
        n_cmp++;
        if (stall_IF_ID !== 1'b0) begin
            n_fail++; $display("FAIL lu_stall_one_cycle: got %b expected 0", stall_IF_ID);
        end
        tick();
        n_cmp++;
        if (ID_EX_rs !== 5'd8 || ID_EX_valid !== 1'b1 || ID_EX_Write_register !== 5'd10 || actual() !== m) begin
            n_fail++; $display("FAIL lu_resume: got %h expected %h", actual(), m);
        end
        n_cmp++;
        if (load_use_count !== (STATS_EN ? 32'd1 : 32'd0)) begin
            n_fail++; $display("FAIL lu_count: got %0d expected %0d", load_use_count, STATS_EN ? 1 : 0);
        end
    endtask

    task automatic test_reg_zero();
        drive_load(5'd0);
        tick();
        clear_id();
        ID_rs = 5'd0; ID_uses_rs = 1'b1; ID_RegWrite = 1'b1; ID_RegDst = 2'b01; ID_rd = 5'd3;
        #2;
        n_cmp++;
        if (stall_IF_ID !== 1'b0) begin
            n_fail++; $display("FAIL r0_no_stall: got %b expected 0", stall_IF_ID);
        end
        tick();
        drive_load(5'd8);
        tick();
        clear_id();
        ID_rs = 5'd1; ID_uses_rs = 1'b1; ID_rt = 5'd8; ID_uses_rt = 1'b0;
        #2;
        n_cmp++;
        if (stall_IF_ID !== 1'b0) begin
            n_fail++; $display("FAIL unused_rt_no_stall: got %b expected 0", stall_IF_ID);
        end
        tick();
        n_cmp++;
        if (ID_EX_valid !== 1'b1 || actual() !== m) begin
            n_fail++; $display("FAIL unused_rt_capture: got %h expected %h", actual(), m);
        end
    endtask

    task automatic test_flush_vs_load_use();
        logic [31:0] lu0, fl0;
        drive_load(5'd8);
        tick();
        lu0 = exp_lu_cnt(); fl0 = exp_fl_cnt();
        clear_id();
        ID_rs = 5'd8; ID_uses_rs = 1'b1; ID_RegWrite = 1'b1; ID_RegDst = 2'b01; ID_rd = 5'd4;
        EX_flush = 1'b1; MEM_hold = 1'b1;
        #2;
        n_cmp++;
        if (stall_IF_ID !== 1'b0) begin
            n_fail++; $display("FAIL flush_no_stall: got %b expected 0", stall_IF_ID);
        end
        tick();
        n_cmp++;
        if (ID_EX_valid !== 1'b0 || actual() !== ex_t'(0)) begin
            n_fail++; $display("FAIL flush_bubble: got %h expected 0", actual());
        end
        n_cmp++;
        if (flush_count !== (STATS_EN ? fl0 + 32'd1 : 32'd0) || load_use_count !== lu0) begin
            n_fail++; $display("FAIL flush_counts: got fl=%0d lu=%0d expected fl=%0d lu=%0d",
                               flush_count, load_use_count, STATS_EN ? fl0 + 1 : 0, lu0);
        end
        EX_flush = 1'b0; MEM_hold = 1'b0;
    endtask

    task automatic test_mem_hold();
        ex_t held;
        clear_id();
        rand_id(31);
        ID_MemRead = 1'b0;
        tick();
        held = actual();
        n_cmp++;
        if (held !== m) begin
            n_fail++; $display("FAIL hold_pre: got %h expected %h", held, m);
        end
        for (int i = 0; i < 3; i++) begin
            rand_id(31);
            MEM_hold = 1'b1;
            #2;
            n_cmp++;
            if (stall_IF_ID !== 1'b1) begin
                n_fail++; $display("FAIL hold_stall[%0d]: got %b expected 1", i, stall_IF_ID);
            end
            tick();
            n_cmp++;
            if (actual() !== held) begin
                n_fail++; $display("FAIL hold_frozen[%0d]: got %h expected %h", i, actual(), held);
            end
        end
        MEM_hold = 1'b0;
    endtask

    task automatic test_regdst();
        logic [1:0] dst_sel [3] = '{2'b10, 2'b01, 2'b01};
        logic       wr_en   [3] = '{1'b1,  1'b1,  1'b0};
        logic [4:0] want    [3] = '{5'd31, 5'd12, 5'd0};
        for (int i = 0; i < 3; i++) begin
            clear_id();
            ID_rd = 5'd12; ID_rt = 5'd7; ID_RegDst = dst_sel[i]; ID_RegWrite = wr_en[i];
            tick();
            n_cmp++;
            if (ID_EX_Write_register !== want[i] || ID_EX_valid !== 1'b1) begin
                n_fail++; $display("FAIL regdst[%0d]: got %0d expected %0d", i, ID_EX_Write_register, want[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_id(3);
            reset    = ($urandom_range(0, 49) == 0);
            EX_flush = ($urandom_range(0, 9) == 0);
            MEM_hold = ($urandom_range(0, 6) == 0);
            #2;
            n_cmp++;
            if (stall_IF_ID !== model_stall()) begin
                n_fail++; $display("FAIL rnd_stall[%0d]: got %b expected %b", i, stall_IF_ID, model_stall());
            end
            tick();
            n_cmp++;
            if (actual() !== m) begin
                n_fail++; $display("FAIL rnd_regs[%0d]: got %h expected %h", i, actual(), m);
            end
            n_cmp++;
            if (load_use_count !== exp_lu_cnt() || flush_count !== exp_fl_cnt()) begin
                n_fail++; $display("FAIL rnd_counts[%0d]: got lu=%0d fl=%0d expected lu=%0d fl=%0d",
                                   i, load_use_count, flush_count, exp_lu_cnt(), exp_fl_cnt());
            end
        end
        clear_id();
    endtask

    initial begin
        m = '0; m_lu_cnt = '0; m_fl_cnt = '0;
        clear_id();
        test_reset();
        test_load_use();
        test_reg_zero();
        test_flush_vs_load_use();
        test_mem_hold();
        test_regdst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
ID/EX pipeline register with integrated load-use hazard detection, sitting directly upstream of the EX forwarding unit.
- Captures decoded operands and control from ID each cycle.
- Resolves the destination register, which feeds EX forwarding and later stages as ID_EX_Write_register.
- Detects load-use hazards against the instruction currently in EX, freezes PC and IF/ID, and injects a bubble.
- Honours branch/jump flush and a downstream memory hold.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register index width
ALUOP_W, 4, ALUOp field width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
ID_rs  in  REG_AW  source register 1 index
ID_rt  in  REG_AW  source register 2 index
ID_rd  in  REG_AW  R-type destination index
ID_uses_rs  in  1  instruction reads rs
ID_uses_rt  in  1  instruction reads rt
ID_RegWrite  in  1  control
ID_MemRead  in  1  control
ID_MemWrite  in  1  control
ID_MemtoReg  in  1  control
ID_RegDst  in  2  00=rt, 01=rd, 10=r31, 11=reserved (treated as rt)
ID_ALUSrc  in  1  control
ID_ALUOp  in  ALUOP_W  control
ID_read_data1  in  DATA_W  register file port 1
ID_read_data2  in  DATA_W  register file port 2
ID_imm_ext  in  DATA_W  extended immediate
ID_PC_plus4  in  DATA_W  PC+4 of the ID instruction
EX_flush  in  1  branch/jump taken in EX: kill the ID instruction
MEM_hold  in  1  downstream memory stall: freeze this register
ID_EX_*  out  (as inputs)  registered copies of every ID_* data and control input except ID_rd, ID_uses_*, ID_RegDst
ID_EX_Write_register  out  REG_AW  resolved destination index
ID_EX_valid  out  1  register holds a real instruction
stall_IF_ID  out  1  hold PC and IF/ID this cycle
load_use_count  out  32  stall statistics (see Optional Feature)
flush_count  out  32  flush statistics (see Optional Feature)

Behaviour:
- Reset (synchronous, active-high on clk): every ID_EX_* output, ID_EX_Write_register and ID_EX_valid clear to 0. Counters clear to 0.
- Bubble: all control outputs 0, ID_EX_valid=0, ID_EX_Write_register=0. Data fields are don't-care but are driven to 0.
- load_use (combinational): ID_EX_valid && ID_EX_MemRead && ID_EX_Write_register!=0 && ((ID_uses_rs && ID_rs==ID_EX_Write_register) || (ID_uses_rt && ID_rt==ID_EX_Write_register)).
- Next-state priority, evaluated per clk edge:
  1. reset
  2. EX_flush → load bubble
  3. MEM_hold → keep current contents
  4. load_use → load bubble
  5. otherwise → capture ID inputs and set ID_EX_valid=1
- stall_IF_ID = !EX_flush && (MEM_hold || load_use). It is combinational and valid in the same cycle the hazard is present.
- Destination resolution at capture: RegDst 00/11→ID_rt, 01→ID_rd, 10→5'd31. If ID_RegWrite=0, ID_EX_Write_register=0.
- Load-use stall lasts exactly 1 cycle. After the bubble, the dependent instruction proceeds; the load reaches MEM/WB and EX forwarding covers it.
- Register 0 never triggers a stall.
- EX_flush together with load_use: flush wins, no stall, bubble loaded.
- EX_flush together with MEM_hold: flush wins.
- Reset asserted mid-stall: registers clear and stall_IF_ID drops the following cycle, since valid=0.

Optional Feature:
HAZARD_STATS_EN.
- Defined: two 32-bit saturating counters.
  - load_use_count increments on each cycle where load_use && !EX_flush && !MEM_hold.
  - flush_count increments on each cycle with EX_flush=1.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: both outputs tied to 0, no flops inferred.

Decomposition:
- Shared package/header holds:
  - RegDst encodings (REGDST_RT, REGDST_RD, REGDST_RA)
  - REG_RA = 5'd31
  - ALUOP_W
  - bubble control constant
- One natural sub-module: load_use_detect, purely combinational, producing load_use from the ID and ID/EX fields listed above.

Test Plan:
1. Reset held 2 cycles with random ID inputs → all outputs 0, ID_EX_valid=0, stall_IF_ID=0.
2. lw $8 in EX (MemRead=1, Write_register=8), ID add with rs=8, uses_rs=1 → stall_IF_ID=1 for 1 cycle, next cycle ID_EX_valid=0 with all controls 0, following cycle add captured with ID_EX_rs=8.
3. lw $0 in EX, ID rs=0 → no stall; also ID rt=8, uses_rt=0, with lw $8 → no stall.
4. load_use and EX_flush both asserted → stall_IF_ID=0, bubble loaded, flush_count +1, load_use_count unchanged (with HAZARD_STATS_EN).
5. MEM_hold=1 for 3 cycles with changing ID inputs → ID_EX_* outputs constant, stall_IF_ID=1 throughout.
6. RegDst 10 with RegWrite=1 → ID_EX_Write_register=31. RegDst 01 with rd=12 → 12. RegWrite=0 with rd=12 → 0.
